// File: rtl/cruce_scheduler.sv
// rtl/cruce_scheduler.sv - two-road intersection phase scheduler with pedestrian phase
module cruce_scheduler #(
    parameter int T_VERDE     = 4,
    parameter int T_AMARILLO  = 2,
    parameter int T_TODO_ROJO = 1,
    parameter int T_PEATON    = 3,
    parameter int W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Habilitar,
    input  logic       Boton,
    output logic       Rojo_A,
    output logic       Amarillo_A,
    output logic       Verde_A,
    output logic       Rojo_B,
    output logic       Amarillo_B,
    output logic       Verde_B,
    output logic       Pasar_Persona,
    output logic       Espera,
    output logic [2:0] Estado
);

    typedef enum logic [2:0] {
        ROJO_BA    = 3'd0,
        A_VERDE    = 3'd1,
        A_AMARILLO = 3'd2,
        ROJO_AB    = 3'd3,
        B_VERDE    = 3'd4,
        B_AMARILLO = 3'd5,
        PEATON     = 3'd6,
        ILEGAL     = 3'd7
    } state_t;

    // Raw code register so an out-of-range value can be held and recovered from.
    logic [2:0]   state;
    logic [W-1:0] cnt;
    logic         pend;
    logic         sig_b;

    state_t       cur;
    state_t       next_state;
    logic [W-1:0] cnt_next;
    logic         pend_next;
    logic         sig_b_next;
    logic         entering_peaton;

    // Counter preload for a phase: it lasts exactly T_x enabled cycles.
    function automatic logic [W-1:0] load_value(input state_t s);
        logic [W-1:0] v;
        case (s)
            A_VERDE, B_VERDE:       v = W'(T_VERDE - 1);
            A_AMARILLO, B_AMARILLO: v = W'(T_AMARILLO - 1);
            PEATON:                 v = W'(T_PEATON - 1);
            default:                v = W'(T_TODO_ROJO - 1);
        endcase
        return v;
    endfunction

    // State, counter, exit target and pending latch update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ROJO_BA;
            cnt   <= W'(T_TODO_ROJO - 1);
            pend  <= 1'b0;
            sig_b <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            pend  <= pend_next;
            sig_b <= sig_b_next;
        end
    end

    // Next-state: advance only on an enabled zero-count edge; illegal code always recovers.
    always_comb begin
        cur             = state_t'(state);
        next_state      = cur;
        cnt_next        = cnt;
        sig_b_next      = sig_b;
        entering_peaton = 1'b0;
        if (cur == ILEGAL) begin
            next_state = ROJO_BA;
            cnt_next   = load_value(ROJO_BA);
        end else if (Habilitar) begin
            if (cnt == '0) begin
                case (cur)
                    ROJO_BA: begin
                        if (pend) begin
                            next_state = PEATON;
                            sig_b_next = 1'b0;
                        end else begin
                            next_state = A_VERDE;
                        end
                    end
                    A_VERDE:    next_state = A_AMARILLO;
                    A_AMARILLO: next_state = ROJO_AB;
                    ROJO_AB: begin
                        if (pend) begin
                            next_state = PEATON;
                            sig_b_next = 1'b1;
                        end else begin
                            next_state = B_VERDE;
                        end
                    end
                    B_VERDE:    next_state = B_AMARILLO;
                    B_AMARILLO: next_state = ROJO_BA;
                    PEATON:     next_state = sig_b ? B_VERDE : A_VERDE;
                    default:    next_state = ROJO_BA;
                endcase
                cnt_next        = load_value(next_state);
                entering_peaton = (next_state == PEATON);
            end else begin
                cnt_next = cnt - 1'b1;
            end
        end
        // A press on the entry edge is served by the phase being entered.
        pend_next = (pend | Boton) & ~entering_peaton;
    end

    // Moore decode of the light heads from the state register only.
    always_comb begin
        Rojo_A        = 1'b0;
        Amarillo_A    = 1'b0;
        Verde_A       = 1'b0;
        Rojo_B        = 1'b0;
        Amarillo_B    = 1'b0;
        Verde_B       = 1'b0;
        Pasar_Persona = 1'b0;
        case (state_t'(state))
            A_VERDE: begin
                Verde_A = 1'b1;
                Rojo_B  = 1'b1;
            end
            A_AMARILLO: begin
                Amarillo_A = 1'b1;
                Rojo_B     = 1'b1;
            end
            B_VERDE: begin
                Rojo_A  = 1'b1;
                Verde_B = 1'b1;
            end
            B_AMARILLO: begin
                Rojo_A     = 1'b1;
                Amarillo_B = 1'b1;
            end
            PEATON: begin
                Rojo_A        = 1'b1;
                Rojo_B        = 1'b1;
                Pasar_Persona = 1'b1;
            end
            default: begin
                Rojo_A = 1'b1;
                Rojo_B = 1'b1;
            end
        endcase
    end

    assign Espera = pend;
    assign Estado = state;

endmodule

// File: tb/tb_cruce_scheduler.sv
// tb/tb_cruce_scheduler.sv - self-checking bench for cruce_scheduler
module tb_cruce_scheduler;

    logic       clk;
    logic       rst;
    logic       Habilitar;
    logic       Boton;
    logic       Rojo_A, Amarillo_A, Verde_A;
    logic       Rojo_B, Amarillo_B, Verde_B;
    logic       Pasar_Persona, Espera;
    logic [2:0] Estado;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [10:0] RESET_VEC = 11'b100_100_0_0_000;

    cruce_scheduler dut (
        .clk(clk), .rst(rst), .Habilitar(Habilitar), .Boton(Boton),
        .Rojo_A(Rojo_A), .Amarillo_A(Amarillo_A), .Verde_A(Verde_A),
        .Rojo_B(Rojo_B), .Amarillo_B(Amarillo_B), .Verde_B(Verde_B),
        .Pasar_Persona(Pasar_Persona), .Espera(Espera), .Estado(Estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: current phase, cycles left in it, pending request, PEATON exit road.
    int m_state;
    int m_left;
    bit m_pend;
    bit m_sigb;

    function automatic int dur(input int s);
        case (s)
            1, 4:    return 4;
            2, 5:    return 2;
            6:       return 3;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_left  = dur(0);
        m_pend  = 0;
        m_sigb  = 0;
    endtask

    task automatic model_edge(input bit hab, input bit bt);
        bit served = 0;
        int nxt;
        if (hab) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (m_state == 6) begin
                    nxt = m_sigb ? 4 : 1;
                end else begin
                    nxt = (m_state + 1) % 6;
                    if ((m_state == 0 || m_state == 3) && m_pend) begin
                        m_sigb = (m_state == 3);
                        nxt    = 6;
                        served = 1;
                    end
                end
                m_state = nxt;
                m_left  = dur(nxt);
            end
        end
        m_pend = (m_pend | bt) & !served;
    endtask

    function automatic logic [10:0] model_vec();
        logic ga, aa, gb, ab;
        ga = (m_state == 1);
        aa = (m_state == 2);
        gb = (m_state == 4);
        ab = (m_state == 5);
        return {~(ga | aa), aa, ga, ~(gb | ab), ab, gb, (m_state == 6), m_pend, 3'(m_state)};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {Rojo_A, Amarillo_A, Verde_A, Rojo_B, Amarillo_B, Verde_B,
                Pasar_Persona, Espera, Estado};
    endfunction

    task automatic tick(input bit hab, input bit bt);
        Habilitar = hab;
        Boton     = bt;
        @(posedge clk);
        model_edge(hab, bt);
        #1;
    endtask

    task automatic do_reset();
        Habilitar = 1'b1;
        Boton     = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0; Habilitar = 1'b1; Boton = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (dut_vec() !== RESET_VEC) begin
            $display("FAIL reset_async: got %b want %b", dut_vec(), RESET_VEC); n_fail++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec() !== RESET_VEC) begin
            $display("FAIL reset_held: got %b want %b", dut_vec(), RESET_VEC); n_fail++;
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_free_run();
        int tab[16] = '{1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 5, 5, 0, 1, 1};
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            tick(1, 0);
            n_checks++;
            if (Estado !== 3'(tab[e-1])) begin
                $display("FAIL free_run_estado edge %0d: got %0d want %0d", e, Estado, tab[e-1]); n_fail++;
            end
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL free_run_vec edge %0d: got %b want %b", e, dut_vec(), model_vec()); n_fail++;
            end
            n_checks++;
            if ((Verde_A & Verde_B) | Pasar_Persona) begin
                $display("FAIL free_run_safety edge %0d: got VA=%b VB=%b walk=%b want 0", e, Verde_A, Verde_B, Pasar_Persona); n_fail++;
            end
        end
    endtask

    task automatic test_ped_ab();
        int tab[12] = '{1, 1, 1, 1, 2, 2, 3, 6, 6, 6, 4, 4};
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            tick(1, e == 3);
            n_checks++;
            if (Estado !== 3'(tab[e-1])) begin
                $display("FAIL ped_ab_estado edge %0d: got %0d want %0d", e, Estado, tab[e-1]); n_fail++;
            end
            n_checks++;
            if (Espera !== (e >= 3 && e < 8)) begin
                $display("FAIL ped_ab_espera edge %0d: got %b want %b", e, Espera, (e >= 3 && e < 8)); n_fail++;
            end
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL ped_ab_vec edge %0d: got %b want %b", e, dut_vec(), model_vec()); n_fail++;
            end
        end
    endtask

    task automatic test_ped_ba_repeat();
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            tick(1, (e == 9) || (e >= 15 && e <= 17));
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL ped_ba_vec edge %0d: got %b want %b", e, dut_vec(), model_vec()); n_fail++;
            end
            if (e == 15 || e == 25) begin
                n_checks++;
                if (Estado !== 3'd6 || Pasar_Persona !== 1'b1) begin
                    $display("FAIL ped_ba_peaton edge %0d: got estado %0d walk %b want 6 1", e, Estado, Pasar_Persona); n_fail++;
                end
            end
            if (e == 18 || e == 28) begin
                n_checks++;
                if (Estado !== ((e == 18) ? 3'd1 : 3'd4)) begin
                    $display("FAIL ped_ba_exit edge %0d: got %0d want %0d", e, Estado, (e == 18) ? 1 : 4); n_fail++;
                end
            end
            if (e == 15 || e == 16) begin
                n_checks++;
                if (Espera !== (e == 16)) begin
                    $display("FAIL ped_ba_espera edge %0d: got %b want %b", e, Espera, (e == 16)); n_fail++;
                end
            end
        end
    endtask

    task automatic test_freeze();
        int n_en;
        do_reset();
        tick(1, 0);
        tick(1, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, i == 2);
            n_checks++;
            if (Estado !== 3'd1) begin
                $display("FAIL freeze_estado step %0d: got %0d want 1", i, Estado); n_fail++;
            end
        end
        n_checks++;
        if (Espera !== 1'b1) begin
            $display("FAIL freeze_espera: got %b want 1", Espera); n_fail++;
        end
        n_en = 0;
        while (Estado == 3'd1 && n_en < 10) begin
            tick(1, 0);
            n_en++;
        end
        n_checks++;
        if (n_en != 3 || Estado !== 3'd2) begin
            $display("FAIL freeze_resume: got %0d cycles estado %0d want 3 cycles estado 2", n_en, Estado); n_fail++;
        end
        n_checks++;
        if (dut_vec() !== model_vec()) begin
            $display("FAIL freeze_vec: got %b want %b", dut_vec(), model_vec()); n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        int tab[15] = '{1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 5, 5, 0, 1};
        do_reset();
        for (int e = 1; e <= 12; e++) tick(1, e == 10);
        n_checks++;
        if (Estado !== 3'd5 || Espera !== 1'b1) begin
            $display("FAIL reset_mid_pre: got estado %0d espera %b want 5 1", Estado, Espera); n_fail++;
        end
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (dut_vec() !== RESET_VEC) begin
            $display("FAIL reset_mid_async: got %b want %b", dut_vec(), RESET_VEC); n_fail++;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int e = 1; e <= 15; e++) begin
            tick(1, 0);
            n_checks++;
            if (Estado !== 3'(tab[e-1]) || dut_vec() !== model_vec()) begin
                $display("FAIL reset_mid_restart edge %0d: got %b want estado %0d vec %b", e, dut_vec(), tab[e-1], model_vec()); n_fail++;
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        for (int e = 1; e <= 3; e++) tick(1, 0);
        Habilitar = 1'b0;
        force dut.state = 3'b111;
        #1;
        n_checks++;
        if (dut_vec() !== {7'b100_100_0, m_pend, 3'b111}) begin
            $display("FAIL illegal_outputs: got %b want %b", dut_vec(), {7'b100_100_0, m_pend, 3'b111}); n_fail++;
        end
        release dut.state;
        @(posedge clk);
        m_state = 0;
        m_left  = dur(0);
        #1;
        n_checks++;
        if (Estado !== 3'd0 || dut_vec() !== model_vec()) begin
            $display("FAIL illegal_recover: got %b want %b", dut_vec(), model_vec()); n_fail++;
        end
        tick(0, 0);
        n_checks++;
        if (Estado !== 3'd0) begin
            $display("FAIL illegal_frozen: got %0d want 0", Estado); n_fail++;
        end
        tick(1, 0);
        n_checks++;
        if (Estado !== 3'd1 || dut_vec() !== model_vec()) begin
            $display("FAIL illegal_to_verde: got %b want %b", dut_vec(), model_vec()); n_fail++;
        end
    endtask

    task automatic test_random();
        bit hab, bt;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            hab = ($urandom_range(0, 7) != 0);
            bt  = ($urandom_range(0, 5) == 0);
            tick(hab, bt);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL random_vec cycle %0d: got %b want %b", i, dut_vec(), model_vec()); n_fail++;
            end
            n_checks++;
            if ((Verde_A | Amarillo_A) & (Verde_B | Amarillo_B)) begin
                $display("FAIL random_safety cycle %0d: got A=%b%b B=%b%b want no conflict", i, Verde_A, Amarillo_A, Verde_B, Amarillo_B); n_fail++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_ped_ab();
        test_ped_ba_repeat();
        test_freeze();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cruce_scheduler.md
# cruce_scheduler

Two-road intersection scheduler that sequences the red/amber/green heads for road A and road B and grants a pedestrian crossing phase on request. It sits above the per-head light decoding: it owns phase order, per-phase durations (down-counter) and pedestrian-request arbitration, and exports its state code for debug. It is a Moore machine: every light output is a decode of the state register only.

## Interface
- T_VERDE, 4: green duration in cycles, must be ≥1 and < 2^W
- T_AMARILLO, 2: amber duration in cycles, ≥1
- T_TODO_ROJO, 1: all-red clearance duration in cycles, ≥1
- T_PEATON, 3: pedestrian phase duration in cycles, ≥1
- W, 8: phase counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Habilitar  in  1  1 = timer runs; 0 = state and counter frozen
- Boton  in  1  pedestrian request, sampled every rising edge
- Rojo_A, Amarillo_A, Verde_A  out  1 each  road A head
- Rojo_B, Amarillo_B, Verde_B  out  1 each  road B head
- Pasar_Persona  out  1  walk indication
- Espera  out  1  pedestrian request pending
- Estado  out  3  current state code

## Operation
- States/codes: ROJO_BA=0, A_VERDE=1, A_AMARILLO=2, ROJO_AB=3, B_VERDE=4, B_AMARILLO=5, PEATON=6; code 7 illegal.
- Order: ROJO_BA → A_VERDE → A_AMARILLO → ROJO_AB → (PEATON if pending) → B_VERDE → B_AMARILLO → ROJO_BA → (PEATON if pending) → A_VERDE.
- PEATON exit target held in 1-bit register sig_B: set to 1 on entry from ROJO_AB, 0 on entry from ROJO_BA; PEATON → B_VERDE if sig_B else A_VERDE.
- Phase timer: on entry to a state, counter loads T_x−1 of that state; decrements each enabled cycle; state advances on the enabled edge where counter==0. Each state lasts exactly T_x enabled cycles.
- Habilitar=0: state, counter, sig_B hold; pending latch still updates.
- Pending latch: pend_next = (pend | Boton) & ~(entering PEATON). Boton asserted on the entry edge to PEATON is absorbed (served). Boton during PEATON re-sets pend for the next all-red. Espera = pend.
- Pending checked only at the counter==0 edge of ROJO_AB/ROJO_BA; requests never shorten green or amber.
- Output decode: A_VERDE: Verde_A,Rojo_B. A_AMARILLO: Amarillo_A,Rojo_B. B_VERDE: Rojo_A,Verde_B. B_AMARILLO: Rojo_A,Amarillo_B. ROJO_AB, ROJO_BA: Rojo_A,Rojo_B. PEATON: Rojo_A,Rojo_B,Pasar_Persona. All unlisted outputs 0. Never green/amber on both roads.
- Illegal code 7: outputs as all-red, next edge → ROJO_BA with counter T_TODO_ROJO−1 regardless of Habilitar.

## Timing
- Reset (async, immediate): state ROJO_BA, counter T_TODO_ROJO−1, pend=0, sig_B=0; outputs Rojo_A=Rojo_B=1, all others 0, Estado=0, Espera=0.
- Reset mid-phase: immediate return to the above; pending request discarded.
- Edge numbering: edge 1 = first rising edge with rst low. Defaults, Habilitar=1, no requests: A_VERDE from edge 1, A_AMARILLO edge 5, ROJO_AB edge 7, B_VERDE edge 8, B_AMARILLO edge 12, ROJO_BA edge 14, A_VERDE edge 15; period 14 cycles.
- Outputs change one clk-to-q after the state edge; Espera rises one edge after Boton sampled high.
- Counter never wraps: load occurs on the same edge as the zero-detect transition.

## Test plan
- Reset then free-run, defaults, no Boton → Estado sequence 0,1,2,3,4,5,0,1 entering at edges 1,5,7,8,12,14,15; no cycle with Verde_A&Verde_B or Pasar_Persona=1.
- Boton pulse 1 cycle at edge 3 → Espera=1 from edge 3; PEATON at edge 8 (Pasar_Persona=1, both red, Espera=0) for 3 cycles; B_VERDE at edge 11.
- Boton during B_VERDE → PEATON after ROJO_BA, then A_VERDE (sig_B=0 path); Boton high throughout PEATON → Espera=1 again after entry edge, second PEATON after next ROJO_AB.
- Habilitar=0 for 5 cycles mid A_VERDE → Estado stays 1, remaining green count resumes unchanged; Boton during freeze sets Espera.
- rst asserted mid B_AMARILLO with Espera=1 → immediately Estado=0, both red, Espera=0; sequence restarts as in scenario 1.
- Force state code 7 (bench deposit) → all-red outputs that cycle, Estado=0 next edge, A_VERDE after T_TODO_ROJO cycles.
